pcie_reset_sequencer: RTL and testbench
=======================================

Name: pcie_reset_sequencer

Overview:
Sequences reset release to the PCIe-side subsystems after the endpoint reaches link-up (e.g. RX engine, TX engine, DMA scheduler, interrupt block). Releases each subsystem's reset in turn, 0 first. Before releasing the next stage it waits a settle interval and a per-stage ready acknowledge. Sits between the endpoint reset generator and the 250 MHz user logic.

Parameters:
NUM_STAGES, 4, number of sequenced subsystems (1..8)
SETTLE_CYCLES, 16, clk250 cycles spent in SETTLE before each release (>=1)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_RDY before timeout (>=2)
CNT_W, 13, counter width; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)

Ports:
clk250  in  1  250 MHz user clock
reset250  in  1  reset; asynchronous, active-high
trn_lnk_up_n  in  1  endpoint link status, active-low (0 = link up)
soft_rst_req  in  1  single-cycle pulse; restarts the sequence
stage_rdy  in  NUM_STAGES  per-stage ready acknowledge, level
sub_reset  out  NUM_STAGES  per-stage reset, active-high, registered
seq_done  out  1  all stages released and ready, registered
seq_err  out  1  stage timeout fault, registered
retry_cnt  out  2  present only with RST_SEQ_RETRY_EN

Behaviour:
- reset250=1 (async): sub_reset=all 1, seq_done=0, seq_err=0, idx=0, counters=0, state=IDLE. Outputs take these values immediately, without a clock edge.
- States:
  - IDLE: all sub_reset=1. If trn_lnk_up_n==0, go to SETTLE and clear the counter.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to RELEASE.
  - RELEASE: sub_reset[idx]<=0, clear the counter, go to WAIT_RDY.
  - WAIT_RDY: stage_rdy[idx] is sampled from the first cycle.
    - If stage_rdy[idx]==1 and idx==NUM_STAGES-1: seq_done<=1, go to DONE.
    - Else if stage_rdy[idx]==1: idx++, go to SETTLE.
    - Else if counter==TIMEOUT_CYCLES-1: go to FAULT, sub_reset<=all 1, seq_err<=1.
    - Else: counter++.
  - DONE: hold all outputs.
  - FAULT: hold sub_reset=all 1 and seq_err=1.
- Released stages stay released. sub_reset is a thermometer code with the low bits cleared first.
- stage_rdy bits other than stage_rdy[idx] are ignored.
- Timing:
  - sub_reset[0] falls on the (SETTLE_CYCLES+1)th edge after the edge that sampled trn_lnk_up_n==0.
  - Successive releases are SETTLE_CYCLES+2 edges apart when stage_rdy is already high.
  - seq_done rises 1 edge after the last release.
- Abort: trn_lnk_up_n==1 or soft_rst_req==1 in any state other than IDLE. It has priority over all transitions. On the next edge: sub_reset=all 1, seq_done=0, seq_err=0, idx=0, state=IDLE.
- Simultaneous events:
  - Abort in the same cycle as stage_rdy or timeout: abort wins.
  - soft_rst_req in IDLE is a no-op.
  - FAULT is left only by abort or reset250.
- Link flap during SETTLE: abort; the settle count restarts from 0 on the next link-up.

Optional Feature:
RST_SEQ_RETRY_EN
- Defined:
  - A WAIT_RDY timeout with retry_cnt<3: retry_cnt++, sub_reset<=all 1, go to IDLE. With the link up, the sequence restarts next cycle.
  - A timeout with retry_cnt==3: go to FAULT.
  - retry_cnt clears on reset250, on abort and on entry to DONE. It saturates at 3.
  - retry_cnt port present.
- Undefined: a timeout goes directly to FAULT. There is no retry_cnt port and no retry logic.

Test Plan:
1. Defaults, stage_rdy=4'b1111, link up at edge T -> sub_reset 1111->1110 at T+17, 1100 at T+35, 1000 at T+53, 0000 at T+71; seq_done=1 at T+72; seq_err=0.
2. stage_rdy[2] held 0 -> sub_reset=1000... reaches 1000 after stage 2 release; after 4096 WAIT_RDY cycles sub_reset=1111, seq_err=1, seq_done=0; stays there until trn_lnk_up_n pulses high.
3. trn_lnk_up_n=1 for one cycle while in SETTLE before stage 1 -> next edge sub_reset=1111, state IDLE; link back -> full sequence restarts with 17-edge first release.
4. soft_rst_req pulse in DONE -> next edge sub_reset=1111, seq_done=0; sequence reruns to seq_done=1 after 72 edges.
5. reset250 asserted asynchronously mid WAIT_RDY (stage 1) -> sub_reset=1111, seq_done=0, seq_err=0 before the next clk250 edge; release of reset250 with link up -> normal sequence.
6. RST_SEQ_RETRY_EN, stage_rdy[1]=0 -> retry_cnt 1,2,3 after successive timeouts with sub_reset=1111 between retries; fourth timeout -> seq_err=1; stage_rdy[1] raised during retry 2 instead -> seq_done=1, retry_cnt=0.

Source files
------------

// File: rtl/pcie_reset_sequencer_if.sv
// pcie_reset_sequencer_if
// Purpose : groups the link status, restart request, per-stage ready
//           acknowledges and sequenced reset outputs of the PCIe reset
//           sequencer into one bundle.
// Signals : trn_lnk_up_n  endpoint link status, active-low
//           soft_rst_req  single-cycle restart pulse
//           stage_rdy     per-stage ready acknowledge (level)
//           sub_reset     per-stage reset, active-high
//           seq_done      all stages released and ready
//           seq_err       stage timeout fault
//           retry_cnt     timeout retry count (RST_SEQ_RETRY_EN builds only)
// Modports: master drives the inputs of the sequencer, slave is the sequencer.
interface pcie_reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic                  trn_lnk_up_n;
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] stage_rdy;
    logic [NUM_STAGES-1:0] sub_reset;
    logic                  seq_done;
    logic                  seq_err;
`ifdef RST_SEQ_RETRY_EN
    logic [1:0]            retry_cnt;

    modport master (output trn_lnk_up_n, soft_rst_req, stage_rdy,
                    input  sub_reset, seq_done, seq_err, retry_cnt);
    modport slave  (input  trn_lnk_up_n, soft_rst_req, stage_rdy,
                    output sub_reset, seq_done, seq_err, retry_cnt);
`else
    modport master (output trn_lnk_up_n, soft_rst_req, stage_rdy,
                    input  sub_reset, seq_done, seq_err);
    modport slave  (input  trn_lnk_up_n, soft_rst_req, stage_rdy,
                    output sub_reset, seq_done, seq_err);
`endif
endinterface

// File: rtl/pcie_reset_sequencer.sv
// pcie_reset_sequencer
// Purpose : after endpoint link-up, releases the resets of NUM_STAGES
//           PCIe-side subsystems one at a time (stage 0 first), waiting a
//           settle interval and the stage's ready acknowledge between
//           releases. Link loss or soft_rst_req restarts the sequence.
// Ports   : clk250    250 MHz user clock
//           reset250  asynchronous active-high reset
//           bus       pcie_reset_sequencer_if.slave (see interface file)
// Option  : define RST_SEQ_RETRY_EN to retry a timed-out sequence up to
//           three times (retry_cnt output) before declaring a fault.
module pcie_reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input  logic clk250,
    input  logic reset250,
    pcie_reset_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_RELEASE, S_WAIT_RDY, S_DONE, S_FAULT
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_STAGES-1:0] r_sub_reset;
    logic                  r_seq_done;
    logic                  r_seq_err;

    logic w_abort;
    logic w_rdy;
    logic w_last;
    logic w_settle_end;
    logic w_timeout;

    // Link loss or restart request outranks every transition outside IDLE.
    assign w_abort      = (r_state != S_IDLE) && (bus.trn_lnk_up_n || bus.soft_rst_req);
    assign w_rdy        = bus.stage_rdy[r_idx];
    assign w_last       = (r_idx == IDX_W'(NUM_STAGES - 1));
    assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign bus.sub_reset = r_sub_reset;
    assign bus.seq_done  = r_seq_done;
    assign bus.seq_err   = r_seq_err;

`ifdef RST_SEQ_RETRY_EN
    logic [1:0] r_retry_cnt;
    assign bus.retry_cnt = r_retry_cnt;
`endif

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk250 or posedge reset250) begin
        if (reset250) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_sub_reset <= '1;
            r_seq_done  <= 1'b0;
            r_seq_err   <= 1'b0;
`ifdef RST_SEQ_RETRY_EN
            r_retry_cnt <= 2'd0;
`endif
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_sub_reset <= '1;
            r_seq_done  <= 1'b0;
            r_seq_err   <= 1'b0;
`ifdef RST_SEQ_RETRY_EN
            r_retry_cnt <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sub_reset <= '1;
                    r_idx       <= '0;
                    if (!bus.trn_lnk_up_n) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_end) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    r_sub_reset[r_idx] <= 1'b0;
                    r_cnt              <= '0;
                    r_state            <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (w_rdy && w_last) begin
                        r_seq_done <= 1'b1;
                        r_state    <= S_DONE;
`ifdef RST_SEQ_RETRY_EN
                        r_retry_cnt <= 2'd0;
`endif
                    end else if (w_rdy) begin
                        // Settle count restarts even if ready arrived late.
                        r_idx   <= r_idx + IDX_W'(1);
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end else if (w_timeout) begin
`ifdef RST_SEQ_RETRY_EN
                        if (r_retry_cnt != 2'd3) begin
                            r_retry_cnt <= r_retry_cnt + 2'd1;
                            r_sub_reset <= '1;
                            r_idx       <= '0;
                            r_cnt       <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_sub_reset <= '1;
                            r_seq_err   <= 1'b1;
                            r_state     <= S_FAULT;
                        end
`else
                        r_sub_reset <= '1;
                        r_seq_err   <= 1'b1;
                        r_state     <= S_FAULT;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                S_FAULT: begin
                    r_sub_reset <= '1;
                    r_seq_err   <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sub_reset <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// tb_pcie_reset_sequencer
// Purpose : directed self-checking bench for pcie_reset_sequencer with
//           default parameters; exercises the retry path when built with
//           RST_SEQ_RETRY_EN and the direct-fault path otherwise.
module tb_pcie_reset_sequencer;
    logic clk250;
    logic reset250;
    int   n_tests;
    int   n_fail;

    pcie_reset_sequencer_if #(.NUM_STAGES(4)) bus ();

    pcie_reset_sequencer #(
        .NUM_STAGES    (4),
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(4096),
        .CNT_W         (13)
    ) dut (
        .clk250  (clk250),
        .reset250(reset250),
        .bus     (bus)
    );

    initial clk250 = 1'b0;
    always #2 clk250 = ~clk250;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk250);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] sr, input logic done, input logic err);
        check({tag, ".sub_reset"}, 32'(bus.sub_reset), 32'(sr));
        check({tag, ".seq_done"},  32'(bus.seq_done),  32'(done));
        check({tag, ".seq_err"},   32'(bus.seq_err),   32'(err));
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        reset250          = 1'b1;
        bus.trn_lnk_up_n  = 1'b1;
        bus.soft_rst_req  = 1'b0;
        bus.stage_rdy     = 4'b1111;

        // Reset values appear before any clock edge.
        #1;
        check_outs("reset_async", 4'b1111, 1'b0, 1'b0);
        tick(2);
        reset250 = 1'b0;
        tick(3);
        check_outs("idle_link_down", 4'b1111, 1'b0, 1'b0);

        // Full sequence, all stages ready.
        bus.trn_lnk_up_n = 1'b0;
        tick(1);   // T
        tick(16);  // T+16
        check("seq.t16", 32'(bus.sub_reset), 32'h0000000f);
        tick(1);   // T+17
        check("seq.t17", 32'(bus.sub_reset), 32'h0000000e);
        tick(17);  // T+34
        check("seq.t34", 32'(bus.sub_reset), 32'h0000000e);
        tick(1);   // T+35
        check("seq.t35", 32'(bus.sub_reset), 32'h0000000c);
        tick(18);  // T+53
        check("seq.t53", 32'(bus.sub_reset), 32'h00000008);
        tick(18);  // T+71
        check_outs("seq.t71", 4'b0000, 1'b0, 1'b0);
        tick(1);   // T+72
        check_outs("seq.t72", 4'b0000, 1'b1, 1'b0);

        // Soft restart from DONE reruns the sequence.
        bus.soft_rst_req = 1'b1;
        tick(1);   // A
        bus.soft_rst_req = 1'b0;
        check_outs("soft.abort", 4'b1111, 1'b0, 1'b0);
        tick(71);  // A+71
        check_outs("soft.a71", 4'b1000, 1'b0, 1'b0);
        tick(1);
        check_outs("soft.a72", 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_outs("soft.a73", 4'b0000, 1'b1, 1'b0);

        // Link flap during the settle before stage 1.
        bus.trn_lnk_up_n = 1'b1;
        tick(1);
        check_outs("linkdown.done", 4'b1111, 1'b0, 1'b0);
        bus.trn_lnk_up_n = 1'b0;
        tick(1);   // T
        tick(17);  // T+17
        check("flap.stage0", 32'(bus.sub_reset), 32'h0000000e);
        tick(8);   // T+25, settling for stage 1
        bus.trn_lnk_up_n = 1'b1;
        tick(1);
        check("flap.abort", 32'(bus.sub_reset), 32'h0000000f);
        bus.trn_lnk_up_n = 1'b0;
        tick(1);   // T2
        tick(16);
        check("flap.t16", 32'(bus.sub_reset), 32'h0000000f);
        tick(1);
        check("flap.t17", 32'(bus.sub_reset), 32'h0000000e);
        tick(54);
        check_outs("flap.t71", 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_outs("flap.t72", 4'b0000, 1'b1, 1'b0);

        // Async reset while waiting on stage 1.
        bus.stage_rdy    = 4'b1101;
        bus.soft_rst_req = 1'b1;
        tick(1);   // A
        bus.soft_rst_req = 1'b0;
        tick(40);  // A+40, stage 1 released, waiting
        check_outs("arst.wait", 4'b1100, 1'b0, 1'b0);
        #1;
        reset250 = 1'b1;
        #1;
        check_outs("arst.mid", 4'b1111, 1'b0, 1'b0);
        @(posedge clk250);
        #1;
        // soft_rst_req while IDLE must not block the link-up start.
        reset250         = 1'b0;
        bus.soft_rst_req = 1'b1;
        bus.stage_rdy    = 4'b1111;
        tick(1);   // T
        bus.soft_rst_req = 1'b0;
        tick(16);
        check("arst.t16", 32'(bus.sub_reset), 32'h0000000f);
        tick(1);
        check("arst.t17", 32'(bus.sub_reset), 32'h0000000e);
        tick(55);
        check_outs("arst.t72", 4'b0000, 1'b1, 1'b0);

`ifndef RST_SEQ_RETRY_EN
        // Stage 2 never ready: timeout fault 4096 cycles after its release.
        bus.stage_rdy    = 4'b1011;
        bus.soft_rst_req = 1'b1;
        tick(1);   // A = T-1
        bus.soft_rst_req = 1'b0;
        tick(53);  // T+52
        check("tmo.t52", 32'(bus.sub_reset), 32'h0000000c);
        tick(1);   // T+53
        check("tmo.t53", 32'(bus.sub_reset), 32'h00000008);
        tick(4095);
        check_outs("tmo.edge_minus1", 4'b1000, 1'b0, 1'b0);
        tick(1);
        check_outs("tmo.fault", 4'b1111, 1'b0, 1'b1);
        bus.stage_rdy = 4'b1111;
        tick(10);
        check_outs("tmo.hold", 4'b1111, 1'b0, 1'b1);
        bus.trn_lnk_up_n = 1'b1;
        tick(1);
        check_outs("tmo.clear", 4'b1111, 1'b0, 1'b0);
        bus.trn_lnk_up_n = 1'b0;
`else
        // Stage 1 never ready: three retries, then fault.
        bus.stage_rdy    = 4'b1101;
        bus.soft_rst_req = 1'b1;
        tick(1);   // A
        bus.soft_rst_req = 1'b0;
        check("retry.start", 32'(bus.retry_cnt), 32'd0);
        tick(4131);
        check("retry.pre1", 32'(bus.sub_reset), 32'h0000000c);
        tick(1);
        check("retry.r1", 32'(bus.retry_cnt), 32'd1);
        check_outs("retry.r1o", 4'b1111, 1'b0, 1'b0);
        tick(4132);
        check("retry.r2", 32'(bus.retry_cnt), 32'd2);
        check_outs("retry.r2o", 4'b1111, 1'b0, 1'b0);
        tick(4132);
        check("retry.r3", 32'(bus.retry_cnt), 32'd3);
        check_outs("retry.r3o", 4'b1111, 1'b0, 1'b0);
        tick(4132);
        check("retry.fault_cnt", 32'(bus.retry_cnt), 32'd3);
        check_outs("retry.fault", 4'b1111, 1'b0, 1'b1);
        bus.trn_lnk_up_n = 1'b1;
        tick(1);   // B
        check("retry.abort_cnt", 32'(bus.retry_cnt), 32'd0);
        check_outs("retry.abort", 4'b1111, 1'b0, 1'b0);
        bus.trn_lnk_up_n = 1'b0;
        tick(8264);
        check("retry.b_r2", 32'(bus.retry_cnt), 32'd2);
        tick(40);  // waiting on stage 1 during retry 2
        bus.stage_rdy = 4'b1111;
        tick(36);
        check("retry.pre_done_cnt", 32'(bus.retry_cnt), 32'd2);
        check_outs("retry.pre_done", 4'b0000, 1'b0, 1'b0);
        tick(1);
        check("retry.done_cnt", 32'(bus.retry_cnt), 32'd0);
        check_outs("retry.done", 4'b0000, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
